// File: rtl/cmd_mem_loader.sv
// ---------------------------------------------------------------------------
// cmd_mem_loader
// Loads and reads back a byte-wide command memory through a 4-bit nibble
// channel driven by an Arduino with a 4-phase strobe/ack handshake.
//
// Ports
//   sysclk              system clock, rising edge
//   arduino_reset       synchronous active-high reset
//   arduino_nibble_in   [3:0] nibble from the Arduino (asynchronous)
//   arduino_mode        [1:0] 00 write data, 01 load address, 10 read, 11 none
//   arduino_strobe      4-phase request (asynchronous)
//   arduino_ack         4-phase acknowledge
//   arduino_nibble_out  [3:0] readback nibble, valid while ack is high in mode 10
//   mem_cmd_dout        [7:0] memory read data
//   mem_cmd_din         [7:0] memory write data
//   mem_cmd_ad          [13:0] memory address
//   mem_cmd_ce/wre/oce/clk  memory chip enable, write enable, output enable, clock
// ---------------------------------------------------------------------------
module cmd_mem_loader (
  input  logic        sysclk,
  input  logic        arduino_reset,
  input  logic [3:0]  arduino_nibble_in,
  input  logic [1:0]  arduino_mode,
  input  logic        arduino_strobe,
  output logic        arduino_ack,
  output logic [3:0]  arduino_nibble_out,
  input  logic [7:0]  mem_cmd_dout,
  output logic [7:0]  mem_cmd_din,
  output logic [13:0] mem_cmd_ad,
  output logic        mem_cmd_ce,
  output logic        mem_cmd_wre,
  output logic        mem_cmd_oce,
  output logic        mem_cmd_clk
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DECODE     = 3'd1,
    ST_MEM_SETUP  = 3'd2,
    ST_MEM_CLK_HI = 3'd3,
    ST_MEM_CLK_LO = 3'd4,
    ST_ACK_HOLD   = 3'd5
  } state_t;

  // Strobe synchronizer and edge detection
  logic       strobe_meta_r;
  logic       strobe_sync_r;
  logic [1:0] sync_valid_r;
  logic       strobe_prev_r;
  logic       strobe_rise_s;

  // FSM and datapath registers with their next values
  state_t      state_r,        state_nx;
  logic [3:0]  nibble_r,       nibble_nx;
  logic [1:0]  mode_r,         mode_nx;
  logic [1:0]  prev_mode_r,    prev_mode_nx;
  logic [1:0]  nibble_count_r, nibble_count_nx;
  logic [3:0]  high_nibble_r,  high_nibble_nx;
  logic [7:0]  byte_r,         byte_nx;
  logic [15:0] addr_shift_r,   addr_shift_nx;
  logic [13:0] reg_address_r,  reg_address_nx;
  logic [7:0]  read_byte_r,    read_byte_nx;
  logic        is_write_r,     is_write_nx;
  logic [3:0]  nibble_out_r,   nibble_out_nx;
  logic        ack_r,          ack_nx;
  logic [7:0]  mem_din_r,      mem_din_nx;
  logic [13:0] mem_ad_r,       mem_ad_nx;
  logic        mem_ce_r,       mem_ce_nx;
  logic        mem_wre_r,      mem_wre_nx;
  logic        mem_oce_r,      mem_oce_nx;
  logic        mem_clk_r,      mem_clk_nx;

  logic [1:0]  count_eff_s;
  logic [15:0] shift_s;
  logic        mem_active_s;
  // The top shifter nibble and the high half of read_byte are shifted out /
  // already forwarded, so nothing downstream consumes them.
  logic        spare_bits_unused_s;

  assign spare_bits_unused_s = ^{addr_shift_r[15:12], read_byte_r[7:4]};

  // A new transaction only starts on a rising synchronized strobe seen in IDLE.
  assign strobe_rise_s = strobe_sync_r & ~strobe_prev_r;

  // A mode change restarts the nibble phase before the count is used.
  assign count_eff_s = (mode_r != prev_mode_r) ? 2'd0 : nibble_count_r;

  assign shift_s = {addr_shift_r[11:0], nibble_r};

  // Two-flop strobe synchronizer plus edge history. The history flop is held
  // at 1 until the synchronizer has refilled after reset, so a strobe that is
  // already high at reset release must fall and rise again to be accepted.
  always_ff @(posedge sysclk) begin
    if (arduino_reset) begin
      strobe_meta_r <= 1'b0;
      strobe_sync_r <= 1'b0;
      sync_valid_r  <= 2'b00;
      strobe_prev_r <= 1'b1;
    end else begin
      strobe_meta_r <= arduino_strobe;
      strobe_sync_r <= strobe_meta_r;
      sync_valid_r  <= {sync_valid_r[0], 1'b1};
      strobe_prev_r <= sync_valid_r[1] ? strobe_sync_r : 1'b1;
    end
  end

  // Next-state and next-register logic; all outputs are registered from these.
  always_comb begin
    state_nx        = state_r;
    nibble_nx       = nibble_r;
    mode_nx         = mode_r;
    prev_mode_nx    = prev_mode_r;
    nibble_count_nx = nibble_count_r;
    high_nibble_nx  = high_nibble_r;
    byte_nx         = byte_r;
    addr_shift_nx   = addr_shift_r;
    reg_address_nx  = reg_address_r;
    read_byte_nx    = read_byte_r;
    is_write_nx     = is_write_r;
    nibble_out_nx   = nibble_out_r;

    case (state_r)
      ST_IDLE: begin
        if (strobe_rise_s) begin
          nibble_nx = arduino_nibble_in;
          mode_nx   = arduino_mode;
          state_nx  = ST_DECODE;
        end else begin
          state_nx  = ST_IDLE;
        end
      end

      ST_DECODE: begin
        prev_mode_nx = mode_r;
        case (mode_r)
          2'b00: begin
            if (count_eff_s == 2'd0) begin
              high_nibble_nx  = nibble_r;
              nibble_count_nx = 2'd1;
              state_nx        = ST_ACK_HOLD;
            end else begin
              byte_nx         = {high_nibble_r, nibble_r};
              nibble_count_nx = 2'd0;
              is_write_nx     = 1'b1;
              state_nx        = ST_MEM_SETUP;
            end
          end
          2'b01: begin
            addr_shift_nx = shift_s;
            if (count_eff_s == 2'd3) begin
              reg_address_nx  = shift_s[13:0];
              nibble_count_nx = 2'd0;
            end else begin
              nibble_count_nx = count_eff_s + 2'd1;
            end
            state_nx = ST_ACK_HOLD;
          end
          2'b10: begin
            if (count_eff_s == 2'd0) begin
              is_write_nx = 1'b0;
              state_nx    = ST_MEM_SETUP;
            end else begin
              nibble_out_nx   = read_byte_r[3:0];
              nibble_count_nx = 2'd0;
              reg_address_nx  = reg_address_r + 14'd1;
              state_nx        = ST_ACK_HOLD;
            end
          end
          default: begin
            nibble_count_nx = count_eff_s;
            state_nx        = ST_ACK_HOLD;
          end
        endcase
      end

      ST_MEM_SETUP: begin
        state_nx = ST_MEM_CLK_HI;
      end

      ST_MEM_CLK_HI: begin
        state_nx = ST_MEM_CLK_LO;
      end

      ST_MEM_CLK_LO: begin
        if (is_write_r) begin
          reg_address_nx = reg_address_r + 14'd1;
        end else begin
          read_byte_nx    = mem_cmd_dout;
          nibble_out_nx   = mem_cmd_dout[7:4];
          nibble_count_nx = 2'd1;
        end
        state_nx = ST_ACK_HOLD;
      end

      ST_ACK_HOLD: begin
        if (!strobe_sync_r) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_ACK_HOLD;
        end
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    // Memory pins are live only in MEM_SETUP and MEM_CLK_HI.
    mem_active_s = (state_nx == ST_MEM_SETUP) || (state_nx == ST_MEM_CLK_HI);
    mem_ce_nx    = mem_active_s;
    mem_wre_nx   = mem_active_s & is_write_nx;
    mem_oce_nx   = mem_active_s & ~is_write_nx;
    mem_clk_nx   = (state_nx == ST_MEM_CLK_HI);
    mem_ad_nx    = mem_active_s ? reg_address_nx : 14'd0;
    mem_din_nx   = (mem_active_s & is_write_nx) ? byte_nx : 8'd0;
    ack_nx       = (state_nx == ST_ACK_HOLD);
  end

  // State, datapath and output registers.
  always_ff @(posedge sysclk) begin
    if (arduino_reset) begin
      state_r        <= ST_IDLE;
      nibble_r       <= 4'd0;
      mode_r         <= 2'd0;
      prev_mode_r    <= 2'd0;
      nibble_count_r <= 2'd0;
      high_nibble_r  <= 4'd0;
      byte_r         <= 8'd0;
      addr_shift_r   <= 16'd0;
      reg_address_r  <= 14'd0;
      read_byte_r    <= 8'd0;
      is_write_r     <= 1'b0;
      nibble_out_r   <= 4'd0;
      ack_r          <= 1'b0;
      mem_din_r      <= 8'd0;
      mem_ad_r       <= 14'd0;
      mem_ce_r       <= 1'b0;
      mem_wre_r      <= 1'b0;
      mem_oce_r      <= 1'b0;
      mem_clk_r      <= 1'b0;
    end else begin
      state_r        <= state_nx;
      nibble_r       <= nibble_nx;
      mode_r         <= mode_nx;
      prev_mode_r    <= prev_mode_nx;
      nibble_count_r <= nibble_count_nx;
      high_nibble_r  <= high_nibble_nx;
      byte_r         <= byte_nx;
      addr_shift_r   <= addr_shift_nx;
      reg_address_r  <= reg_address_nx;
      read_byte_r    <= read_byte_nx;
      is_write_r     <= is_write_nx;
      nibble_out_r   <= nibble_out_nx;
      ack_r          <= ack_nx;
      mem_din_r      <= mem_din_nx;
      mem_ad_r       <= mem_ad_nx;
      mem_ce_r       <= mem_ce_nx;
      mem_wre_r      <= mem_wre_nx;
      mem_oce_r      <= mem_oce_nx;
      mem_clk_r      <= mem_clk_nx;
    end
  end

  assign arduino_ack        = ack_r;
  assign arduino_nibble_out = nibble_out_r;
  assign mem_cmd_din        = mem_din_r;
  assign mem_cmd_ad         = mem_ad_r;
  assign mem_cmd_ce         = mem_ce_r;
  assign mem_cmd_wre        = mem_wre_r;
  assign mem_cmd_oce        = mem_oce_r;
  assign mem_cmd_clk        = mem_clk_r;

endmodule

// File: tb/tb_cmd_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_cmd_mem_loader
// Self-checking bench: drives the Arduino nibble handshake, models the
// command memory, and compares memory writes and readback nibbles against
// expectations queued when each stimulus is issued.
// ---------------------------------------------------------------------------
module tb_cmd_mem_loader;

  logic        sysclk = 1'b0;
  logic        arduino_reset;
  logic [3:0]  arduino_nibble_in;
  logic [1:0]  arduino_mode;
  logic        arduino_strobe;
  logic        arduino_ack;
  logic [3:0]  arduino_nibble_out;
  logic [7:0]  mem_cmd_dout = 8'h00;
  logic [7:0]  mem_cmd_din;
  logic [13:0] mem_cmd_ad;
  logic        mem_cmd_ce;
  logic        mem_cmd_wre;
  logic        mem_cmd_oce;
  logic        mem_cmd_clk;

  cmd_mem_loader dut (
    .sysclk             (sysclk),
    .arduino_reset      (arduino_reset),
    .arduino_nibble_in  (arduino_nibble_in),
    .arduino_mode       (arduino_mode),
    .arduino_strobe     (arduino_strobe),
    .arduino_ack        (arduino_ack),
    .arduino_nibble_out (arduino_nibble_out),
    .mem_cmd_dout       (mem_cmd_dout),
    .mem_cmd_din        (mem_cmd_din),
    .mem_cmd_ad         (mem_cmd_ad),
    .mem_cmd_ce         (mem_cmd_ce),
    .mem_cmd_wre        (mem_cmd_wre),
    .mem_cmd_oce        (mem_cmd_oce),
    .mem_cmd_clk        (mem_cmd_clk)
  );

  always #5 sysclk = ~sysclk;

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard state
  logic [21:0] exp_wr_q[$];
  logic [3:0]  exp_rd_q[$];
  logic [21:0] wr_exp;
  int          pulses      = 0;
  int          exp_pulses  = 0;
  int          wre_rd_cnt  = 0;
  logic        rd_window   = 1'b0;
  logic [7:0]  mem [0:16383];

  // Synchronous command memory model; each write is checked against the queue.
  always @(posedge mem_cmd_clk) begin
    pulses++;
    if (mem_cmd_ce && mem_cmd_wre) begin
      mem[mem_cmd_ad] = mem_cmd_din;
      if (exp_wr_q.size() != 0) begin
        wr_exp = exp_wr_q.pop_front();
        chk("mem_write", {10'd0, mem_cmd_ad, mem_cmd_din}, {10'd0, wr_exp});
      end
    end else if (mem_cmd_ce && mem_cmd_oce) begin
      mem_cmd_dout <= mem[mem_cmd_ad];
    end
  end

  // Write enable must never rise during the read sequence.
  always @(negedge sysclk) begin
    if (rd_window && mem_cmd_wre) wre_rd_cnt++;
  end

  task automatic push_wr(input logic [13:0] addr, input logic [7:0] data);
    exp_wr_q.push_back({addr, data});
    exp_pulses++;
  endtask

  task automatic chk_outs_zero(input string tag);
    chk(tag, {1'b0, arduino_ack, arduino_nibble_out, mem_cmd_din, mem_cmd_ad,
              mem_cmd_ce, mem_cmd_wre, mem_cmd_oce, mem_cmd_clk}, 32'd0);
  endtask

  // One full 4-phase nibble transfer. Strobe rises just after a falling edge:
  // two cycles of synchronizer, then 2 (register) or 5 (memory) cycles to ack.
  // Ack must drop 3 cycles after the strobe falls.
  task automatic send(input logic [1:0] mode, input logic [3:0] nib,
                      input logic is_mem, input int hold);
    int lat;
    int drop;
    int n;
    logic [3:0] e;
    @(negedge sysclk);
    arduino_mode      = mode;
    arduino_nibble_in = nib;
    arduino_strobe    = 1'b1;
    lat = 0;
    do begin
      @(posedge sysclk); #1;
      lat++;
    end while (!arduino_ack && lat < 40);
    chk("ack_latency", lat, is_mem ? 32'd7 : 32'd4);
    if (mode == 2'b10) begin
      if (exp_rd_q.size() != 0) begin
        e = exp_rd_q.pop_front();
        chk("rd_nibble", {28'd0, arduino_nibble_out}, {28'd0, e});
      end else begin
        chk("rd_queue", exp_rd_q.size(), 32'd1);
      end
    end
    drop = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge sysclk); #1;
      if (!arduino_ack) drop++;
    end
    chk("ack_held", drop, 32'd0);
    arduino_strobe = 1'b0;
    n = 0;
    do begin
      @(posedge sysclk); #1;
      n++;
    end while (arduino_ack && n < 40);
    chk("ack_fall", n, 32'd3);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0;
    int n;
    int ack_seen;

    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[2] = 8'h5A;
    arduino_reset     = 1'b1;
    arduino_strobe    = 1'b0;
    arduino_nibble_in = 4'h0;
    arduino_mode      = 2'b00;
    repeat (3) @(posedge sysclk);
    #1;
    chk_outs_zero("reset_outputs");
    @(negedge sysclk);
    arduino_reset = 1'b0;
    repeat (3) @(posedge sysclk);

    // Basic write: nibbles 0,1 -> 0x01 at address 0, exactly one clock pulse.
    p0 = pulses;
    push_wr(14'h0000, 8'h01);
    send(2'b00, 4'h0, 1'b0, 0);
    send(2'b00, 4'h1, 1'b1, 0);
    chk("one_pulse", pulses - p0, 32'd1);
    // Address advanced to 1.
    push_wr(14'h0001, 8'h22);
    send(2'b00, 4'h2, 1'b0, 0);
    send(2'b00, 4'h2, 1'b1, 0);

    // Address FFFF (top bits dropped) then wrap 0x3FFF -> 0x0000.
    for (int i = 0; i < 4; i++) send(2'b01, 4'hF, 1'b0, 0);
    push_wr(14'h3FFF, 8'hAB);
    push_wr(14'h0000, 8'hCD);
    send(2'b00, 4'hA, 1'b0, 0);
    send(2'b00, 4'hB, 1'b1, 0);
    send(2'b00, 4'hC, 1'b0, 0);
    send(2'b00, 4'hD, 1'b1, 0);

    // Readback of 0x5A at address 2.
    send(2'b01, 4'h0, 1'b0, 0);
    send(2'b01, 4'h0, 1'b0, 0);
    send(2'b01, 4'h0, 1'b0, 0);
    send(2'b01, 4'h2, 1'b0, 0);
    exp_rd_q.push_back(4'h5);
    exp_rd_q.push_back(4'hA);
    exp_pulses++;
    rd_window = 1'b1;
    send(2'b10, 4'h0, 1'b1, 0);
    send(2'b10, 4'h0, 1'b0, 0);
    rd_window = 1'b0;
    chk("rd_wre_low", wre_rd_cnt, 32'd0);
    // Address advanced to 3; readback nibble holds across other modes.
    push_wr(14'h0003, 8'h77);
    send(2'b00, 4'h7, 1'b0, 0);
    send(2'b00, 4'h7, 1'b1, 0);
    chk("nibble_out_hold", {28'd0, arduino_nibble_out}, 32'hA);

    // Mode change restarts the nibble phase: stray high nibble is discarded.
    send(2'b00, 4'h3, 1'b0, 0);
    send(2'b01, 4'h0, 1'b0, 0);
    send(2'b01, 4'h0, 1'b0, 0);
    send(2'b01, 4'h1, 1'b0, 0);
    send(2'b01, 4'h0, 1'b0, 0);
    push_wr(14'h0010, 8'h9E);
    send(2'b00, 4'h9, 1'b0, 0);
    send(2'b00, 4'hE, 1'b1, 0);

    // Strobe held for 20 cycles: one transaction per strobe, ack held.
    push_wr(14'h0011, 8'h45);
    send(2'b00, 4'h4, 1'b0, 20);
    send(2'b00, 4'h5, 1'b1, 20);

    // Reset while in MEM_CLK_HI, with the strobe kept high across release.
    send(2'b00, 4'h6, 1'b0, 0);
    push_wr(14'h0012, 8'h68);
    @(negedge sysclk);
    arduino_mode      = 2'b00;
    arduino_nibble_in = 4'h8;
    arduino_strobe    = 1'b1;
    n = 0;
    while (!mem_cmd_clk && n < 40) begin
      @(negedge sysclk);
      n++;
    end
    chk("reach_clk_hi", {31'd0, mem_cmd_clk}, 32'd1);
    arduino_reset = 1'b1;
    @(posedge sysclk); #1;
    chk_outs_zero("mid_reset_outputs");
    p0 = pulses;
    @(negedge sysclk);
    arduino_reset = 1'b0;
    ack_seen = 0;
    repeat (10) begin
      @(posedge sysclk); #1;
      if (arduino_ack) ack_seen++;
    end
    chk("no_start_high_strobe", ack_seen, 32'd0);
    chk("no_clk_after_reset", pulses - p0, 32'd0);
    arduino_strobe = 1'b0;
    repeat (4) @(posedge sysclk);
    // Address back at 0 and nibble phase cleared.
    push_wr(14'h0000, 8'h3C);
    send(2'b00, 4'h3, 1'b0, 0);
    send(2'b00, 4'hC, 1'b1, 0);

    repeat (4) @(posedge sysclk);
    chk("total_clk_pulses", pulses, exp_pulses);
    chk("wr_queue_left", exp_wr_q.size(), 32'd0);
    chk("rd_queue_left", exp_rd_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/cmd_mem_loader.md
CMD_MEM_LOADER -- requirements
Module: cmd_mem_loader

Interface
REQ-001 Clock and reset SHALL be: one clock; reset is synchronous and active-high. Clock port is sysclk; reset port is arduino_reset.
REQ-002 sysclk  input  1  system clock; every register updates on its rising edge.
REQ-003 arduino_reset  input  1  synchronous active-high reset.
REQ-004 arduino_nibble_in  input  4  nibble from the Arduino; asynchronous to sysclk.
REQ-005 arduino_mode  input  2  operation select: 00 write data, 01 load address, 10 read data, 11 reserved; asynchronous.
REQ-006 arduino_strobe  input  1  4-phase request from the Arduino; asynchronous.
REQ-007 arduino_ack  output  1  4-phase acknowledge to the Arduino.
REQ-008 arduino_nibble_out  output  4  readback nibble; valid while arduino_ack is high in mode 10.
REQ-009 mem_cmd_dout  input  8  command memory read data.
REQ-010 mem_cmd_din  output  8  command memory write data.
REQ-011 mem_cmd_ad  output  14  command memory address.
REQ-012 mem_cmd_ce, mem_cmd_wre, mem_cmd_oce, mem_cmd_clk  output  1 each  command memory chip enable, write enable, output enable and clock.

Function
REQ-013 arduino_strobe SHALL pass through a 2-flop synchronizer; only a 0->1 edge at the synchronizer output starts a transaction.
REQ-014 arduino_nibble_in and arduino_mode SHALL be registered in the cycle the synchronized rising edge is detected.
REQ-015 The FSM SHALL have these states: IDLE, DECODE, MEM_SETUP, MEM_CLK_HI, MEM_CLK_LO, ACK_HOLD.
- IDLE -> DECODE on a detected strobe edge.
REQ-016 DECODE rules:
- If the mode differs from the previous nibble's mode, nibble_count is cleared to 0 before use.
- mode 00, count 0: store the high nibble, count=1, go to ACK_HOLD.
- mode 00, count 1: form byte {high, low}, count=0, go to MEM_SETUP (write).
- mode 01: shift the nibble into a 16-bit address shifter, count++; on count 3, reg_address <= shifter[13:0] (top 2 bits discarded), count=0; go to ACK_HOLD.
- mode 10, count 0: go to MEM_SETUP (read).
- mode 10, count 1: arduino_nibble_out <= read_byte[3:0], count=0, increment reg_address, go to ACK_HOLD.
- mode 11: no effect, go to ACK_HOLD.
REQ-017 MEM_SETUP SHALL drive mem_cmd_ad=reg_address and mem_cmd_ce=1. For a write it drives mem_cmd_wre=1, mem_cmd_oce=0 and mem_cmd_din=byte; for a read it drives mem_cmd_wre=0 and mem_cmd_oce=1.
REQ-018 MEM_CLK_HI SHALL set mem_cmd_clk=1.
REQ-019 MEM_CLK_LO actions:
- Sets mem_cmd_clk=0, ce=0, wre=0, oce=0.
- On a read, captures mem_cmd_dout into read_byte and drives arduino_nibble_out <= mem_cmd_dout[7:4], count=1.
- On a write, increments reg_address.
- Goes to ACK_HOLD.
REQ-020 ACK_HOLD SHALL hold arduino_ack=1 until the synchronized strobe is 0, then set arduino_ack=0 and return to IDLE.
REQ-021 Strobe edges SHALL NOT be detected in any state other than IDLE.
REQ-022 reg_address SHALL wrap from 0x3FFF to 0x0000.
REQ-023 Latency from synchronized strobe edge to arduino_ack=1 SHALL be 2 cycles for non-memory nibbles and 5 cycles for memory nibbles.
REQ-024 arduino_nibble_out SHALL hold its value until the next read-mode update.
REQ-025 Memory control outputs SHALL be 0 in every state except MEM_SETUP and MEM_CLK_HI.

Reset
REQ-026 While arduino_reset=1, at every rising edge the module SHALL:
- set all outputs to 0;
- clear reg_address, nibble_count, address shifter, read_byte and the previous-mode register to 0;
- clear the synchronizer to 0;
- put the FSM in IDLE.
REQ-027 Reset asserted mid-transaction (including MEM_CLK_HI) SHALL abort it with no further memory clock edge and no address increment.
REQ-028 After reset release, a strobe already high SHALL NOT start a transaction until it has returned low and risen again.

Verification
REQ-029 Reset, then nibbles 0x0 and 0x1 in mode 00 -> one write: ad=0x0000, din=0x01, wre=1, exactly one mem_cmd_clk pulse; reg_address=1.
REQ-030 Mode 01 nibbles F,F,F,F, then a mode 00 byte 0xAB followed by 0xCD -> 0xAB written at 0x3FFF, 0xCD written at 0x0000 (wrap).
REQ-031 Memory preloaded 0x5A at address 2, mode 01 nibbles 0,0,0,2, then mode 10 two strobes -> arduino_nibble_out=0x5 then 0xA; reg_address=3; wre stays 0 throughout.
REQ-032 Mode 00 nibble 0x3, then mode 01 (change) nibbles 0,0,1,0 -> no memory write; reg_address=0x0010, nibble phase restarted.
REQ-033 arduino_reset pulsed while the FSM is in MEM_CLK_HI -> next cycle all outputs 0, state IDLE, reg_address unchanged from 0.
REQ-034 Strobe held high for 20 cycles -> arduino_ack rises after the specified latency, stays high until the strobe falls, and exactly one transaction occurs.
